// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters; optional starvation guard via ARB_STARVE_GUARD_EN
module mem_arbiter #(
  parameter int MAXDSTREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wmask,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
  state_t state, nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wmask_q;
  logic we_q, trip, grant_d, grant_i;
  if (MAXDSTREAK < 1 || MAXDSTREAK > 7) begin : g_bad_streak
    $error("MAXDSTREAK must fit the 3-bit streak counter (1..7)");
  end
`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] streak;
  assign trip = i_req && (streak == 3'(MAXDSTREAK));
  // count back-to-back data grants that left a fetch waiting
  always_ff @(posedge clk)
    if (!reset_n) streak <= '0;
    else if (grant_d) streak <= i_req ? streak + 3'd1 : '0;
    else if (grant_i) streak <= '0;
`else
  assign trip = 1'b0;
`endif
  assign grant_d = state == IDLE && nxt == DACC;
  assign grant_i = state == IDLE && nxt == IACC;
  // next state and completion strobes
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = (d_req && !trip) ? DACC : i_req ? IACC : IDLE;
    else if (m_ready) nxt = IDLE;
    i_done = state == IACC && m_ready;
    d_done = state == DACC && m_ready;
    busy = state != IDLE;
  end
  // state register and payload latched at grant
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q <= 1'b0;
    end else begin
      state <= nxt;
      if (grant_d) begin
        addr_q <= d_addr;
        wdata_q <= d_wdata;
        wmask_q <= d_wmask;
        we_q <= d_we;
      end else if (grant_i) begin
        addr_q <= i_addr;
        wmask_q <= '0;
        we_q <= 1'b0;
      end
    end
  assign m_req = busy;
  assign m_we = busy & we_q;
  assign m_wmask = busy ? wmask_q : '0;
  assign m_addr = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
endmodule
